update_tableau_lanes: RTL and testbench
=======================================

UPDATE_TABLEAU_LANES -- requirements
Module: update_tableau_lanes

Interface
REQ-001 Parameter DATA_W, default 32, fixed-point element width (signed two's complement).
REQ-002 Parameter FRAC_W, default 16, fractional bits of every element.
REQ-003 Parameter LANES, default 4, elements per stream beat.
REQ-004 Parameter MAX_COLS, default 1024, pivot-row buffer depth in elements (multiple of LANES).
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; latches num_rows, num_cols, pivot_row_idx.
- num_rows  in  16  tableau rows; last row is the objective row.
- num_cols  in  16  tableau columns; last column is RHS.
- pivot_row_idx  in  16  index of the pivot row.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last result beat is accepted.
- cont, terminate  out  1 each  optimality verdict, held until next start.
- s_axis_pivot_row_tdata/tvalid/tready  in/in/out  LANES*DATA_W/1/1  normalised pivot row r[j].
- s_axis_pivot_column_tdata/tvalid/tready  in/in/out  DATA_W/1/1  one pivot-column element c[i] per row.
- s_axis_tableau_tdata/tvalid/tready  in/in/out  LANES*DATA_W/1/1  tableau row-major T[i][j]; lane k = column base+k.
- m_axis_result_tdata/tvalid/tready/tlast/tkeep  out/out/in/out/out  LANES*DATA_W/1/1/1/LANES  updated tableau.

Function
REQ-006 FSM states IDLE, LOAD_ROW, UPDATE, DRAIN, DONE; start honoured only in IDLE, ignored otherwise.
REQ-007 beats_per_row = ceil(num_cols/LANES); num_cols above MAX_COLS is clamped to MAX_COLS.
REQ-008 num_rows==0 or num_cols==0: IDLE->DONE directly, no stream traffic, terminate=1, cont=0.
REQ-009 LOAD_ROW: accept exactly beats_per_row pivot-row beats into buffer, then go to UPDATE.
REQ-010 UPDATE: per row, the first tableau beat is accepted only together with one pivot-column beat (both tready high in the same cycle only when both valid); c[i] is held for the remaining beats of the row.
REQ-011 Result for i != pivot_row_idx: T[i][j] - ((c[i]*r[j]) >>> FRAC_W), product at 2*DATA_W bits, arithmetic shift (floor), subtraction at DATA_W+1 bits.
REQ-012 Result for i == pivot_row_idx: r[j] unchanged; c[i] still consumed.
REQ-013 Lanes with column >= num_cols output zero with tkeep bit 0; tlast on the last beat of every row.
REQ-014 Two-stage pipeline, latency 2 cycles input-accept to m_axis_result_tvalid; stage advance = !m_axis_result_tvalid || m_axis_result_tready; no beat lost or duplicated under any backpressure pattern.
REQ-015 After the last tableau beat is accepted, enter DRAIN until pipeline empty, then DONE (one cycle, done=1), then IDLE.
REQ-016 Verdict: cont=1 if any objective-row result in columns 0..num_cols-2 is negative, else terminate=1; exactly one of cont/terminate is high after DONE; both low while busy.

Reset
REQ-017 reset clears FSM to IDLE, counters, pipeline valids; busy, done, cont, terminate, all tready and m_axis_result_tvalid low; other output data zero; buffer contents not cleared.
REQ-018 reset mid-operation aborts the job with no done pulse; the next start behaves as after power-up.

Configuration
REQ-019 Macro UPDATE_TABLEAU_SAT_EN defined: results outside the signed DATA_W range saturate to max/min; undefined: the low DATA_W bits are output (wrap).

Verification
REQ-020 2x4, LANES=4, pivot_row_idx=0, r={1,2,3,4}, c={1,2}, T row1={10,10,10,10} (Q16.16) -> row0={1,2,3,4}, row1={8,6,4,2}, terminate=1.
REQ-021 Objective row result containing -1.0 (0xFFFF0000) in column 0 -> cont=1, terminate=0 after done.
REQ-022 num_cols=5, LANES=4 -> 2 beats/row, second beat tkeep=0001, lanes 1-3 zero, tlast on beat 2.
REQ-023 T=0x7FFF0000, c=-1.0, r=1.0 -> 0x7FFFFFFF with UPDATE_TABLEAU_SAT_EN, 0x80000000 (wrap) without.
REQ-024 Random m_axis_result_tready (50%) and random input valids over 8x16 tableau -> output matches reference model beat-for-beat.
REQ-025 reset asserted mid-UPDATE then new start with num_rows=0 -> no output, done one cycle later, terminate=1.

Source files
------------

// File: rtl/update_tableau_lanes.sv
// rtl/update_tableau_lanes.sv - simplex tableau row update (T - c*r), LANES elements per beat
// Optional: define UPDATE_TABLEAU_SAT_EN to saturate results instead of wrapping.
module update_tableau_lanes #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int LANES    = 4,
  parameter int MAX_COLS = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             num_rows,
  input  logic [15:0]             num_cols,
  input  logic [15:0]             pivot_row_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    cont,
  output logic                    terminate,
  input  logic [LANES*DATA_W-1:0] s_axis_pivot_row_tdata,
  input  logic                    s_axis_pivot_row_tvalid,
  output logic                    s_axis_pivot_row_tready,
  input  logic [DATA_W-1:0]       s_axis_pivot_column_tdata,
  input  logic                    s_axis_pivot_column_tvalid,
  output logic                    s_axis_pivot_column_tready,
  input  logic [LANES*DATA_W-1:0] s_axis_tableau_tdata,
  input  logic                    s_axis_tableau_tvalid,
  output logic                    s_axis_tableau_tready,
  output logic [LANES*DATA_W-1:0] m_axis_result_tdata,
  output logic                    m_axis_result_tvalid,
  input  logic                    m_axis_result_tready,
  output logic                    m_axis_result_tlast,
  output logic [LANES-1:0]        m_axis_result_tkeep
);
  localparam int BW    = LANES * DATA_W;
  localparam int DEPTH = MAX_COLS / LANES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW1   = DATA_W + 1;
  localparam int DW2   = 2 * DATA_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       rows_q, cols_q, prow_q, bpr_q, row_q, beat_q;
  logic [DATA_W-1:0] c_q;
  logic              neg_q, cont_q, term_q;
  logic [BW-1:0]     buf_mem [DEPTH];

  logic              s1_vld_q, s1_piv_q, s1_obj_q, s1_last_q;
  logic [BW-1:0]     s1_t_q, s1_r_q;
  logic [DATA_W-1:0] s1_c_q;
  logic [15:0]       s1_beat_q;

  logic              out_vld_q, out_last_q;
  logic [BW-1:0]     out_data_q;
  logic [LANES-1:0]  out_keep_q;

  logic [15:0]       cols_clamp, bpr_new;
  logic              adv, first, last_beat, last_row, row_acc, tab_acc, both_vld;
  logic [BW-1:0]     res_data;
  logic [LANES-1:0]  res_keep;
  logic              res_neg;

  assign cols_clamp = (num_cols > 16'(MAX_COLS)) ? 16'(MAX_COLS) : num_cols;
  assign bpr_new    = (cols_clamp + 16'(LANES - 1)) / 16'(LANES);

  // Whole pipeline moves together whenever the output register can take a beat.
  assign adv       = !out_vld_q || m_axis_result_tready;
  assign first     = (beat_q == 16'd0);
  assign last_beat = (beat_q == bpr_q - 16'd1);
  assign last_row  = (row_q == rows_q - 16'd1);
  assign both_vld  = s_axis_tableau_tvalid && s_axis_pivot_column_tvalid;

  assign s_axis_pivot_row_tready    = (state_q == S_LOAD);
  assign s_axis_tableau_tready      = (state_q == S_UPDATE) && adv && (!first || both_vld);
  assign s_axis_pivot_column_tready = (state_q == S_UPDATE) && adv && first && both_vld;
  assign row_acc = s_axis_pivot_row_tready && s_axis_pivot_row_tvalid;
  assign tab_acc = s_axis_tableau_tready && s_axis_tableau_tvalid;

  assign busy                 = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done                 = (state_q == S_DONE);
  assign cont                 = cont_q;
  assign terminate            = term_q;
  assign m_axis_result_tdata  = out_data_q;
  assign m_axis_result_tvalid = out_vld_q;
  assign m_axis_result_tlast  = out_last_q;
  assign m_axis_result_tkeep  = out_keep_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_rows == 16'd0 || num_cols == 16'd0) ? S_DONE : S_LOAD;
      S_LOAD:   if (row_acc && last_beat) state_d = S_UPDATE;
      S_UPDATE: if (tab_acc && last_beat && last_row) state_d = S_DRAIN;
      S_DRAIN:  if (!s1_vld_q && !out_vld_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic signed [DATA_W-1:0] t_s, r_s, c_s, val;
    logic signed [DW2-1:0]    prod;
    logic [31:0]              col;
`ifdef UPDATE_TABLEAU_SAT_EN
    logic [DW1-1:0]           diff;
`endif
    res_data = '0;
    res_keep = '0;
    res_neg  = 1'b0;
    c_s      = s1_c_q;
    for (int k = 0; k < LANES; k++) begin
      t_s  = s1_t_q[k*DATA_W +: DATA_W];
      r_s  = s1_r_q[k*DATA_W +: DATA_W];
      prod = DW2'(c_s) * DW2'(r_s);
`ifdef UPDATE_TABLEAU_SAT_EN
      diff = {t_s[DATA_W-1], t_s} - DW1'(prod >>> FRAC_W);
      if (diff[DATA_W] != diff[DATA_W-1])
        val = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
        val = diff[DATA_W-1:0];
`else
      val = t_s - DATA_W'(prod >>> FRAC_W);
`endif
      if (s1_piv_q) val = r_s;
      col = 32'(s1_beat_q) * 32'(LANES) + 32'(k);
      if (col < {16'd0, cols_q}) begin
        res_keep[k] = 1'b1;
        res_data[k*DATA_W +: DATA_W] = val;
        if (s1_obj_q && (col + 32'd1 < {16'd0, cols_q}) && val[DATA_W-1]) res_neg = 1'b1;
      end
    end
  end

  // Pivot-row buffer is plain storage; it is never cleared.
  always_ff @(posedge clk) begin
    if (row_acc) buf_mem[beat_q[AW-1:0]] <= s_axis_pivot_row_tdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      prow_q     <= '0;
      bpr_q      <= '0;
      row_q      <= '0;
      beat_q     <= '0;
      c_q        <= '0;
      neg_q      <= 1'b0;
      cont_q     <= 1'b0;
      term_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_piv_q   <= 1'b0;
      s1_obj_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_t_q     <= '0;
      s1_r_q     <= '0;
      s1_c_q     <= '0;
      s1_beat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        rows_q <= num_rows;
        cols_q <= cols_clamp;
        prow_q <= pivot_row_idx;
        bpr_q  <= bpr_new;
        row_q  <= '0;
        beat_q <= '0;
        neg_q  <= 1'b0;
        cont_q <= 1'b0;
        term_q <= 1'b0;
      end
      if (row_acc) beat_q <= last_beat ? 16'd0 : beat_q + 16'd1;
      if (tab_acc) begin
        if (first) c_q <= s_axis_pivot_column_tdata;
        if (last_beat) begin
          beat_q <= '0;
          row_q  <= row_q + 16'd1;
        end else begin
          beat_q <= beat_q + 16'd1;
        end
      end
      if (adv) begin
        s1_vld_q <= tab_acc;
        if (tab_acc) begin
          s1_t_q    <= s_axis_tableau_tdata;
          s1_r_q    <= buf_mem[beat_q[AW-1:0]];
          s1_c_q    <= first ? s_axis_pivot_column_tdata : c_q;
          s1_piv_q  <= (row_q == prow_q);
          s1_obj_q  <= last_row;
          s1_beat_q <= beat_q;
          s1_last_q <= last_beat;
        end
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_data_q <= res_data;
          out_keep_q <= res_keep;
          out_last_q <= s1_last_q;
          if (res_neg) neg_q <= 1'b1;
        end
      end
      // An empty job (IDLE->DONE) always reports terminate.
      if (state_d == S_DONE && state_q != S_DONE) begin
        cont_q <= (state_q == S_DRAIN) && neg_q;
        term_q <= !((state_q == S_DRAIN) && neg_q);
      end
    end
  end
endmodule

// File: tb/tb_update_tableau_lanes.sv
// tb/tb_update_tableau_lanes.sv - directed checks for update_tableau_lanes (DATA_W=32, FRAC_W=16, LANES=4)
`timescale 1ns/1ps
module tb_update_tableau_lanes;
  typedef logic [132:0] ent_t;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0]  num_rows = '0, num_cols = '0, pivot_row_idx = '0;
  logic         busy, done, cont, terminate;
  logic [127:0] pr_tdata = '0;
  logic         pr_tvalid = 1'b0, pr_tready;
  logic [31:0]  pc_tdata = '0;
  logic         pc_tvalid = 1'b0, pc_tready;
  logic [127:0] tb_tdata = '0;
  logic         tb_tvalid = 1'b0, tb_tready;
  logic [127:0] m_tdata;
  logic         m_tvalid, m_tready = 1'b1, m_tlast;
  logic [3:0]   m_tkeep;

  logic [31:0] R [16];
  logic [31:0] C [8];
  logic [31:0] T [8][16];
  ent_t exp_q[$];
  ent_t got[$];
  int   n_cmp = 0, n_bad = 0, done_cnt = 0;
  bit   rnd_rdy = 1'b0;

  update_tableau_lanes dut (
    .clk(clk), .reset(reset), .start(start),
    .num_rows(num_rows), .num_cols(num_cols), .pivot_row_idx(pivot_row_idx),
    .busy(busy), .done(done), .cont(cont), .terminate(terminate),
    .s_axis_pivot_row_tdata(pr_tdata), .s_axis_pivot_row_tvalid(pr_tvalid),
    .s_axis_pivot_row_tready(pr_tready),
    .s_axis_pivot_column_tdata(pc_tdata), .s_axis_pivot_column_tvalid(pc_tvalid),
    .s_axis_pivot_column_tready(pc_tready),
    .s_axis_tableau_tdata(tb_tdata), .s_axis_tableau_tvalid(tb_tvalid),
    .s_axis_tableau_tready(tb_tready),
    .m_axis_result_tdata(m_tdata), .m_axis_result_tvalid(m_tvalid),
    .m_axis_result_tready(m_tready), .m_axis_result_tlast(m_tlast),
    .m_axis_result_tkeep(m_tkeep)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) got.push_back({m_tlast, m_tkeep, m_tdata});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic ent_t mk(bit last, logic [3:0] keep, logic [31:0] a0, a1, a2, a3);
    return {last, keep, a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] pack_r(int b, int nc);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = (b*4 + k < nc) ? R[b*4 + k] : 32'hDEADBEEF;
    return v;
  endfunction

  function automatic logic [127:0] pack_t(int i, int b, int nc);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = (b*4 + k < nc) ? T[i][b*4 + k] : 32'hDEADBEEF;
    return v;
  endfunction

  // Reference: T - floor(c*r / 2^16), 33-bit difference, wrap or saturate
  function automatic logic [31:0] ref_elem(logic [31:0] t, logic [31:0] c, logic [31:0] r, bit piv);
    longint p;
    logic [32:0] d;
    if (piv) return r;
    p = longint'($signed(c)) * longint'($signed(r));
    p = p >>> 16;
    d = {t[31], t} - 33'(p);
`ifdef UPDATE_TABLEAU_SAT_EN
    if (d[32] != d[31]) return d[32] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return d[31:0];
  endfunction

  task automatic clear_arrays();
    for (int j = 0; j < 16; j++) R[j] = '0;
    for (int i = 0; i < 8; i++) begin
      C[i] = '0;
      for (int j = 0; j < 16; j++) T[i][j] = '0;
    end
    exp_q.delete();
  endtask

  task automatic send_pivot(input logic [127:0] d, input bit rnd);
    bit ok;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    pr_tdata = d;
    pr_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      #1;
      ok = pr_tready;
      @(negedge clk);
    end
    pr_tvalid = 1'b0;
    chk("pivot_row_handshake", 133'(ok), 133'd1);
  endtask

  task automatic send_tab(input logic [127:0] d, input logic [31:0] c, input bit first, input bit rnd);
    bit ok, okc;
    int cdly;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    cdly = (first && rnd) ? int'($urandom_range(0, 2)) : 0;
    tb_tdata = d;
    tb_tvalid = 1'b1;
    pc_tdata = c;
    ok = 1'b0;
    okc = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (first && cdly == 0) pc_tvalid = 1'b1;
      #1;
      ok = tb_tready;
      okc = pc_tready;
      @(negedge clk);
      if (cdly > 0) cdly--;
    end
    tb_tvalid = 1'b0;
    pc_tvalid = 1'b0;
    chk("tableau_handshake", 133'(ok), 133'd1);
    chk("column_ready_pairing", 133'(okc), 133'(first));
  endtask

  task automatic run_job(input int nr, input int nc, input int pidx, input bit rnd, input bit exp_cont);
    int bpr, d0;
    bit ok;
    got.delete();
    d0 = done_cnt;
    num_rows = 16'(nr);
    num_cols = 16'(nc);
    pivot_row_idx = 16'(pidx);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 133'(busy), 133'd1);
    chk("verdict_low_while_busy", 133'({cont, terminate}), 133'd0);
    bpr = (nc + 3) / 4;
    for (int b = 0; b < bpr; b++) send_pivot(pack_r(b, nc), rnd);
    for (int i = 0; i < nr; i++)
      for (int b = 0; b < bpr; b++) send_tab(pack_t(i, b, nc), C[i], b == 0, rnd);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 133'(ok), 133'd1);
    chk("verdict_at_done", 133'({cont, terminate}), 133'({exp_cont, !exp_cont}));
    chk("busy_low_at_done", 133'(busy), 133'd0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 133'(done), 133'd0);
    chk("done_pulse_count", 133'(done_cnt - d0), 133'd1);
    chk("verdict_held", 133'({cont, terminate}), 133'({exp_cont, !exp_cont}));
    chk("beat_count", 133'(got.size()), 133'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk($sformatf("beat%0d", i), got[i], exp_q[i]);
  endtask

  initial begin
    int d0;
    bit neg;
    logic [31:0] v;
    logic [31:0] e23;
    logic [127:0] rd;

    repeat (3) @(negedge clk);
    chk("rst_busy", 133'(busy), 133'd0);
    chk("rst_done", 133'(done), 133'd0);
    chk("rst_verdict", 133'({cont, terminate}), 133'd0);
    chk("rst_treadys", 133'({pr_tready, pc_tready, tb_tready}), 133'd0);
    chk("rst_tvalid", 133'(m_tvalid), 133'd0);
    chk("rst_tdata", 133'({m_tlast, m_tkeep, m_tdata}), 133'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2x4: row0 = pivot row, row1 = 10 - 2*r
    clear_arrays();
    R[0] = 32'h10000; R[1] = 32'h20000; R[2] = 32'h30000; R[3] = 32'h40000;
    C[0] = 32'h10000; C[1] = 32'h20000;
    for (int j = 0; j < 4; j++) begin
      T[0][j] = 32'h1234_5678;
      T[1][j] = 32'hA0000;
    end
    exp_q.push_back(mk(1'b1, 4'hF, 32'h10000, 32'h20000, 32'h30000, 32'h40000));
    exp_q.push_back(mk(1'b1, 4'hF, 32'h80000, 32'h60000, 32'h40000, 32'h20000));
    run_job(2, 4, 0, 1'b0, 1'b0);

    // Objective row has -1.0 in column 0
    clear_arrays();
    R[0] = 32'h10000;
    C[0] = 32'h10000;
    T[1][0] = 32'hFFFF0000; T[1][1] = 32'h10000;
    exp_q.push_back(mk(1'b1, 4'h3, 32'h10000, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(1'b1, 4'h3, 32'hFFFF0000, 32'h10000, 32'h0, 32'h0));
    run_job(2, 2, 0, 1'b0, 1'b1);

    // Negative value only in the RHS column does not count
    clear_arrays();
    R[0] = 32'h12345; R[1] = 32'h3;
    T[0][0] = 32'h10000; T[0][1] = 32'hFFFF0000;
    exp_q.push_back(mk(1'b1, 4'h3, 32'h10000, 32'hFFFF0000, 32'h0, 32'h0));
    run_job(1, 2, 1, 1'b0, 1'b0);

    // num_cols=5: two beats per row, second beat keeps lane 0 only
    clear_arrays();
    for (int j = 0; j < 5; j++) R[j] = 32'((j + 1) << 16);
    C[0] = 32'h7;
    exp_q.push_back(mk(1'b0, 4'hF, 32'h10000, 32'h20000, 32'h30000, 32'h40000));
    exp_q.push_back(mk(1'b1, 4'h1, 32'h50000, 32'h0, 32'h0, 32'h0));
    run_job(1, 5, 0, 1'b0, 1'b0);

    // Overflow: 0x7FFF0000 - (-1.0 * 1.0)
`ifdef UPDATE_TABLEAU_SAT_EN
    e23 = 32'h7FFFFFFF;
`else
    e23 = 32'h80000000;
`endif
    clear_arrays();
    R[0] = 32'h10000;
    C[0] = 32'h10000; C[1] = 32'hFFFF0000;
    T[1][0] = 32'h7FFF0000;
    exp_q.push_back(mk(1'b1, 4'h1, 32'h10000, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(1'b1, 4'h1, e23, 32'h0, 32'h0, 32'h0));
    run_job(2, 1, 0, 1'b0, 1'b0);

    // 8x16 random data, random valids and result backpressure
    clear_arrays();
    for (int j = 0; j < 16; j++) R[j] = $urandom;
    for (int i = 0; i < 8; i++) begin
      C[i] = $urandom;
      for (int j = 0; j < 16; j++) T[i][j] = $urandom;
    end
    neg = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 4; k++) begin
          v = ref_elem(T[i][b*4 + k], C[i], R[b*4 + k], i == 3);
          rd[k*32 +: 32] = v;
          if (i == 7 && b*4 + k < 15 && v[31]) neg = 1'b1;
        end
        exp_q.push_back({b == 3, 4'hF, rd});
      end
    rnd_rdy = 1'b1;
    run_job(8, 16, 3, 1'b1, neg);
    rnd_rdy = 1'b0;

    // Reset mid-UPDATE, then an empty job
    d0 = done_cnt;
    num_rows = 16'd8; num_cols = 16'd16; pivot_row_idx = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 4; b++) send_pivot(pack_r(b, 16), 1'b0);
    send_tab(pack_t(0, 0, 16), C[0], 1'b1, 1'b0);
    send_tab(pack_t(0, 1, 16), C[0], 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 133'(busy), 133'd0);
    chk("abort_tvalid", 133'(m_tvalid), 133'd0);
    chk("abort_treadys", 133'({pr_tready, pc_tready, tb_tready}), 133'd0);
    chk("abort_tdata", 133'(m_tdata), 133'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_no_done", 133'(done_cnt - d0), 133'd0);
    got.delete();
    num_rows = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", 133'(done), 133'd1);
    chk("empty_verdict", 133'({cont, terminate}), 133'b01);
    chk("empty_no_traffic", 133'({pr_tready, pc_tready, tb_tready, m_tvalid}), 133'd0);
    @(negedge clk);
    #1;
    chk("empty_done_low", 133'(done), 133'd0);
    chk("empty_no_output", 133'(got.size()), 133'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
